// File: rtl/ex_mem_pkg.sv
// Shared types for the EX->MEM pipeline register: payload layout, ALU flag indices, occupancy states.
// The flag field exists only when EX_MEM_FLAGS_EN is defined.
package ex_mem_pkg;

  localparam int unsigned XLEN_P   = 32;
  localparam int unsigned REG_AW_P = 5;

  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_t;

  typedef struct packed {
    logic [XLEN_P-1:0]   result;
`ifdef EX_MEM_FLAGS_EN
    logic [3:0]          flags;
`endif
    logic [REG_AW_P-1:0] rd;
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic [2:0]          funct3;
    logic [XLEN_P-1:0]   store_data;
  } ex_mem_payload_t;

endpackage

// File: rtl/skid_buf2.sv
// Generic 2-entry skid buffer: in_ready and out_valid come straight from flops, output is FIFO-ordered.
module skid_buf2
  import ex_mem_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  occ_t         state;
  logic [W-1:0] main_q;
  logic [W-1:0] skid_q;

  assign out_data = main_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= OCC_EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else if (flush) begin
      state     <= OCC_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      unique case (state)
        OCC_EMPTY: begin
          if (in_valid) begin
            main_q    <= in_data;
            state     <= OCC_ONE;
            out_valid <= 1'b1;
          end
        end
        OCC_ONE: begin
          if (in_valid && out_ready) begin
            main_q <= in_data;
          end else if (in_valid) begin
            skid_q   <= in_data;
            state    <= OCC_FULL;
            in_ready <= 1'b0;
          end else if (out_ready) begin
            state     <= OCC_EMPTY;
            out_valid <= 1'b0;
          end
        end
        OCC_FULL: begin
          // in_ready is low here, so nothing can be accepted while draining the skid entry
          if (out_ready) begin
            main_q   <= skid_q;
            state    <= OCC_ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= OCC_EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/ex_mem_reg.sv
// EX->MEM pipeline register: packs ALU outputs into a payload held by a 2-entry skid buffer.
// Define EX_MEM_FLAGS_EN to carry the {Z,N,C,V} ALU flags alongside the payload.
module ex_mem_reg
  import ex_mem_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_P,
  parameter int unsigned REG_AW = REG_AW_P
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_result,
`ifdef EX_MEM_FLAGS_EN
  input  logic [3:0]        in_flags,
`endif
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_reg_write,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic [2:0]        in_funct3,
  input  logic [XLEN-1:0]   in_store_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_result,
`ifdef EX_MEM_FLAGS_EN
  output logic [3:0]        out_flags,
`endif
  output logic [REG_AW-1:0] out_rd,
  output logic              out_reg_write,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic [2:0]        out_funct3,
  output logic [XLEN-1:0]   out_store_data
);

  ex_mem_payload_t in_pl;
  ex_mem_payload_t out_pl;

  // x0 is hardwired to zero, so a write to it is dropped at capture time
  always_comb begin
    in_pl            = '0;
    in_pl.result     = in_result;
`ifdef EX_MEM_FLAGS_EN
    in_pl.flags      = in_flags;
`endif
    in_pl.rd         = in_rd;
    in_pl.reg_write  = in_reg_write && (in_rd != '0);
    in_pl.mem_read   = in_mem_read;
    in_pl.mem_write  = in_mem_write;
    in_pl.funct3     = in_funct3;
    in_pl.store_data = in_store_data;
  end

  skid_buf2 #(
    .W($bits(ex_mem_payload_t))
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_pl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_pl)
  );

  assign out_result     = out_pl.result;
`ifdef EX_MEM_FLAGS_EN
  assign out_flags      = out_pl.flags;
`endif
  assign out_rd         = out_pl.rd;
  assign out_reg_write  = out_pl.reg_write;
  assign out_mem_read   = out_pl.mem_read;
  assign out_mem_write  = out_pl.mem_write;
  assign out_funct3     = out_pl.funct3;
  assign out_store_data = out_pl.store_data;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Bench for ex_mem_reg: directed vector table plus randomized traffic against a queue-based reference model.
module tb_ex_mem_reg;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_result, in_store_data, out_result, out_store_data;
  logic [4:0]  in_rd, out_rd;
  logic        in_reg_write, in_mem_read, in_mem_write;
  logic        out_reg_write, out_mem_read, out_mem_write;
  logic [2:0]  in_funct3, out_funct3;
`ifdef EX_MEM_FLAGS_EN
  logic [3:0]  in_flags, out_flags;
`endif

  always #5 clk = ~clk;

  ex_mem_reg #(.XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result),
`ifdef EX_MEM_FLAGS_EN
    .in_flags(in_flags),
`endif
    .in_rd(in_rd), .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
    .in_mem_write(in_mem_write), .in_funct3(in_funct3), .in_store_data(in_store_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result),
`ifdef EX_MEM_FLAGS_EN
    .out_flags(out_flags),
`endif
    .out_rd(out_rd), .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .out_funct3(out_funct3), .out_store_data(out_store_data)
  );

  typedef struct {
    logic [31:0] result;
    logic [3:0]  flags;
    logic [4:0]  rd;
    logic        rw, mr, mw;
    logic [2:0]  f3;
    logic [31:0] sd;
  } beat_t;

  // Reference: the register behaves as a FIFO of depth 2
  beat_t q[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    beat_t b;
    bit    room;
    room        = (q.size() < 2);
    b.result    = in_result;
`ifdef EX_MEM_FLAGS_EN
    b.flags     = in_flags;
`else
    b.flags     = 4'h0;
`endif
    b.rd        = in_rd;
    b.rw        = in_reg_write && (in_rd != 5'd0);
    b.mr        = in_mem_read;
    b.mw        = in_mem_write;
    b.f3        = in_funct3;
    b.sd        = in_store_data;
    @(posedge clk);
    if (rst || flush) q.delete();
    else begin
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (in_valid && room) q.push_back(b);
    end
    #1;
    chk("model_out_valid", 64'(out_valid), 64'(q.size() > 0));
    chk("model_in_ready", 64'(in_ready), 64'(q.size() < 2));
    if (q.size() > 0) begin
      chk("model_result", 64'(out_result), 64'(q[0].result));
      chk("model_rd", 64'(out_rd), 64'(q[0].rd));
      chk("model_reg_write", 64'(out_reg_write), 64'(q[0].rw));
      chk("model_mem_rw", 64'({out_mem_read, out_mem_write}), 64'({q[0].mr, q[0].mw}));
      chk("model_funct3", 64'(out_funct3), 64'(q[0].f3));
      chk("model_store_data", 64'(out_store_data), 64'(q[0].sd));
`ifdef EX_MEM_FLAGS_EN
      chk("model_flags", 64'(out_flags), 64'(q[0].flags));
`endif
    end
  endtask

  task automatic idle_inputs();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_result = '0; in_rd = '0; in_reg_write = 1'b0; in_mem_read = 1'b0;
    in_mem_write = 1'b0; in_funct3 = '0; in_store_data = '0;
`ifdef EX_MEM_FLAGS_EN
    in_flags = '0;
`endif
  endtask

  typedef struct {
    logic        v;
    logic [31:0] res;
    logic [4:0]  rd;
    logic        rw, ordy, fl;
    logic        e_ov, e_ir, chk_pay;
    logic [31:0] e_res;
    logic        e_rw;
  } vec_t;

  vec_t tbl[18];

  initial begin
    idle_inputs();

    // Reset for two cycles with junk offered on the input
    rst = 1'b1; in_valid = 1'b1; in_result = 32'hDEAD_BEEF; in_rd = 5'd3; in_reg_write = 1'b1;
    tick(); tick();
    idle_inputs();
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_result", 64'(out_result), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);

    //            v  res       rd    rw ordy fl   e_ov e_ir chk  e_res     e_rw
    tbl[0]  = '{1, 32'h11, 5'd1, 1, 1, 0,  1, 1, 1, 32'h11, 1};
    tbl[1]  = '{1, 32'h22, 5'd1, 1, 1, 0,  1, 1, 1, 32'h22, 1};
    tbl[2]  = '{1, 32'h33, 5'd1, 1, 1, 0,  1, 1, 1, 32'h33, 1};
    tbl[3]  = '{1, 32'h44, 5'd1, 1, 1, 0,  1, 1, 1, 32'h44, 1};
    tbl[4]  = '{0, 32'h0,  5'd0, 0, 1, 0,  0, 1, 0, 32'h0,  0};
    tbl[5]  = '{1, 32'hA,  5'd1, 1, 0, 0,  1, 1, 1, 32'hA,  1};
    tbl[6]  = '{1, 32'hB,  5'd1, 1, 0, 0,  1, 0, 1, 32'hA,  1};
    tbl[7]  = '{1, 32'hC,  5'd1, 1, 0, 0,  1, 0, 1, 32'hA,  1};
    tbl[8]  = '{1, 32'hC,  5'd1, 1, 1, 0,  1, 1, 1, 32'hB,  1};
    tbl[9]  = '{1, 32'hC,  5'd1, 1, 1, 0,  1, 1, 1, 32'hC,  1};
    tbl[10] = '{0, 32'h0,  5'd0, 0, 1, 0,  0, 1, 0, 32'h0,  0};
    tbl[11] = '{1, 32'hA,  5'd1, 1, 0, 0,  1, 1, 1, 32'hA,  1};
    tbl[12] = '{1, 32'hB,  5'd1, 1, 0, 0,  1, 0, 1, 32'hA,  1};
    tbl[13] = '{1, 32'hC,  5'd1, 1, 1, 1,  0, 1, 0, 32'h0,  0};
    tbl[14] = '{0, 32'h0,  5'd0, 0, 1, 0,  0, 1, 0, 32'h0,  0};
    tbl[15] = '{1, 32'h5,  5'd0, 1, 1, 0,  1, 1, 1, 32'h5,  0};
    tbl[16] = '{1, 32'h6,  5'd7, 1, 1, 0,  1, 1, 1, 32'h6,  1};
    tbl[17] = '{0, 32'h0,  5'd0, 0, 1, 0,  0, 1, 0, 32'h0,  0};

    // Flags follow each beat as the inverted low nibble of its result (0x5 -> 4'b1010)
    for (int i = 0; i < 18; i++) begin
      in_valid = tbl[i].v; in_result = tbl[i].res; in_rd = tbl[i].rd;
      in_reg_write = tbl[i].rw; out_ready = tbl[i].ordy; flush = tbl[i].fl;
`ifdef EX_MEM_FLAGS_EN
      in_flags = ~tbl[i].res[3:0];
`endif
      tick();
      chk($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].e_ov));
      chk($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].e_ir));
      if (tbl[i].chk_pay) begin
        chk($sformatf("vec%0d_result", i), 64'(out_result), 64'(tbl[i].e_res));
        chk($sformatf("vec%0d_reg_write", i), 64'(out_reg_write), 64'(tbl[i].e_rw));
`ifdef EX_MEM_FLAGS_EN
        chk($sformatf("vec%0d_flags", i), 64'(out_flags), 64'({~tbl[i].e_res[3:0]}));
`endif
      end
    end
    idle_inputs();

    // Reset while FULL, with flush also asserted: everything discarded, payload zeroed
    in_valid = 1'b1; in_result = 32'h77; in_rd = 5'd2; in_reg_write = 1'b1;
    tick();
    in_result = 32'h88;
    tick();
    chk("full_before_reset", 64'(in_ready), 64'd0);
    rst = 1'b1; flush = 1'b1; out_ready = 1'b1;
    tick();
    idle_inputs();
    chk("midreset_out_valid", 64'(out_valid), 64'd0);
    chk("midreset_result", 64'(out_result), 64'd0);
    chk("midreset_reg_write", 64'(out_reg_write), 64'd0);
    chk("midreset_in_ready", 64'(in_ready), 64'd1);

    // Randomized traffic against the queue model
    for (int n = 0; n < 600; n++) begin
      rst           = ($urandom_range(0, 149) == 0);
      flush         = ($urandom_range(0, 39) == 0);
      in_valid      = ($urandom_range(0, 9) < 7);
      out_ready     = ($urandom_range(0, 9) < 6);
      in_result     = $urandom;
      in_rd         = 5'($urandom_range(0, 3));
      in_reg_write  = 1'($urandom);
      in_mem_read   = 1'($urandom);
      in_mem_write  = 1'($urandom);
      in_funct3     = 3'($urandom);
      in_store_data = $urandom;
`ifdef EX_MEM_FLAGS_EN
      in_flags      = 4'($urandom);
`endif
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
